// File: rtl/rio_pkg.sv
// rio_pkg: shared state encoding and frame geometry for the RIO serial initiator
package rio_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_WDATA,
    ST_TA,
    ST_RDATA,
    ST_END
  } state_e;
  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned WR_FRAME_BITS = 18;
  localparam int unsigned RD_FRAME_BITS = 19;
endpackage

// File: rtl/rio_bit_timer.sv
// rio_bit_timer: half-period tick, end-of-bit strobe and clock_target generation
//   clock, reset_n  : clock and asynchronous active-low reset
//   start_i         : begin a frame; first bit period starts next cycle with clock_target low
//   stop_i          : end the frame; clock_target returns to its idle-high level
//   eob_o           : high on the last clock cycle of every bit period
//   clock_target_o  : serial clock, low for the first CLKDIV cycles of a bit, high for the rest
module rio_bit_timer #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start_i,
  input  logic stop_i,
  output logic eob_o,
  output logic clock_target_o
);
  logic       active_q;
  logic       phase_q;
  logic       clk_q;
  logic [7:0] hcnt_q;
  logic       tick;
  assign tick           = active_q && (hcnt_q == 8'(CLKDIV - 1));
  assign eob_o          = tick && phase_q;
  assign clock_target_o = clk_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      clk_q    <= 1'b1;
      hcnt_q   <= 8'd0;
    end else if (start_i) begin
      active_q <= 1'b1;
      phase_q  <= 1'b0;
      clk_q    <= 1'b0;
      hcnt_q   <= 8'd0;
    end else if (stop_i) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      clk_q    <= 1'b1;
      hcnt_q   <= 8'd0;
    end else if (active_q) begin
      hcnt_q <= tick ? 8'd0 : hcnt_q + 8'd1;
      // clock_target follows the phase: low half then high half of each bit
      if (tick) begin
        phase_q <= !phase_q;
        clk_q   <= !phase_q;
      end
    end
  end
endmodule

// File: rtl/rio_initiator.sv
// rio_initiator: host-side engine for the RIO 3-wire register bus (clock_target + shared sdio)
//   clock, reset_n                         : clock and asynchronous active-low reset
//   req_valid/req_ready                    : request handshake, ready only while idle
//   req_write, req_addr, req_wdata         : captured on accept
//   rsp_valid, rsp_rdata                   : one-cycle pulse and held data when a read completes
//   clock_target                           : serial clock, idles high
//   sdio_o, sdio_oe, sdio_i                : split tristate of the pulled-up sdio line
module rio_initiator
  import rio_pkg::*;
#(
  parameter int unsigned CLKDIV = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       clock_target,
  output logic       sdio_o,
  output logic       sdio_oe,
  input  logic       sdio_i
);
  state_e      state_q;
  logic [2:0]  bit_q;
  logic        write_q;
  logic [15:0] tx_q;
  logic [7:0]  rx_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        sdio_o_q;
  logic        sdio_oe_q;
  logic        eob;
  logic        accept;
  logic        last_bit;
  logic        frame_end;
  assign accept    = req_valid && req_ready_q;
  assign last_bit  = bit_q == 3'(DATA_BITS - 1);
  assign frame_end = (state_q == ST_END) && eob;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sdio_o    = sdio_o_q;
  assign sdio_oe   = sdio_oe_q;
  rio_bit_timer #(.CLKDIV(CLKDIV)) u_timer (
    .clock         (clock),
    .reset_n       (reset_n),
    .start_i       (accept),
    .stop_i        (frame_end),
    .eob_o         (eob),
    .clock_target_o(clock_target)
  );
  // sdio_o only changes on an end-of-bit edge (start of the next bit), so the
  // target always sees stable data across the rising edge of clock_target.
  // tx_q holds {rw, addr, wdata} and is shifted out MSB first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_q       <= 3'd0;
      write_q     <= 1'b0;
      tx_q        <= 16'd0;
      rx_q        <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      sdio_o_q    <= 1'b1;
      sdio_oe_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          state_q     <= ST_START;
          req_ready_q <= 1'b0;
          write_q     <= req_write;
          tx_q        <= {req_write, req_addr, req_wdata};
          sdio_o_q    <= 1'b0;
          sdio_oe_q   <= 1'b1;
        end
        ST_START: if (eob) begin
          state_q  <= ST_CMD;
          sdio_o_q <= tx_q[15];
          tx_q     <= tx_q << 1;
        end
        ST_CMD: if (eob) begin
          bit_q     <= bit_q + 3'd1;
          tx_q      <= tx_q << 1;
          sdio_o_q  <= (last_bit && !write_q) ? 1'b1 : tx_q[15];
          sdio_oe_q <= !(last_bit && !write_q);
          if (last_bit) state_q <= write_q ? ST_WDATA : ST_TA;
        end
        ST_WDATA: if (eob) begin
          bit_q     <= bit_q + 3'd1;
          tx_q      <= tx_q << 1;
          sdio_o_q  <= last_bit ? 1'b1 : tx_q[15];
          sdio_oe_q <= !last_bit;
          if (last_bit) state_q <= ST_END;
        end
        ST_TA: if (eob) state_q <= ST_RDATA;
        ST_RDATA: if (eob) begin
          bit_q <= bit_q + 3'd1;
          rx_q  <= {rx_q[6:0], sdio_i};
          if (last_bit) state_q <= ST_END;
        end
        ST_END: if (eob) begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= !write_q;
          if (!write_q) rsp_rdata_q <= rx_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rio_initiator.sv
// tb_rio_initiator: randomized self-checking bench with a bit-level target model for CLKDIV=2 and CLKDIV=1
module tb_rio_initiator;
  logic clock = 1'b0;
  logic reset_n;
  logic [1:0] rv, rw, rdy, rspv, ct, so, soe, si;
  logic [1:0][6:0] ra;
  logic [1:0][7:0] wd, rdata;
  int vectors = 0;
  int miscompares = 0;
  logic [1:0][18:0] obs_o, obs_oe;
  int nbits[2], busy[2], low[2], rsp_cnt[2], rsp_at[2], since[2], fidx[2];
  logic [1:0] is_read, tdrv_en, tdrv, prev_ct, prev_rdy, respond;
  logic [1:0][7:0] tdata, exp_rd;
  always #5 clock = ~clock;
  rio_initiator #(.CLKDIV(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(wd[0]), .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]),
    .clock_target(ct[0]), .sdio_o(so[0]), .sdio_oe(soe[0]), .sdio_i(si[0]));
  rio_initiator #(.CLKDIV(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(wd[1]), .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]),
    .clock_target(ct[1]), .sdio_o(so[1]), .sdio_oe(soe[1]), .sdio_i(si[1]));
  for (genvar g = 0; g < 2; g++) begin : g_line
    assign si[g] = soe[g] ? so[g] : (tdrv_en[g] ? tdrv[g] : 1'b1);
  end
  // Bus monitor and target: frames are delimited by req_ready, bits are taken on
  // rising clock_target, the target drives read data after falling clock_target.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (prev_rdy[k] && !rdy[k]) begin
        since[k] = 0; fidx[k] = -1; nbits[k] = 0; busy[k] = 0; low[k] = 0;
        rsp_cnt[k] = 0; rsp_at[k] = -1; obs_o[k] = '0; obs_oe[k] = '0; is_read[k] = 1'b0;
      end else since[k]++;
      if (!rdy[k]) begin
        busy[k]++;
        if (!ct[k]) low[k]++;
        if (!prev_ct[k] && ct[k]) begin
          if (nbits[k] == 1) is_read[k] = !so[k];
          obs_o[k] = {obs_o[k][17:0], so[k]};
          obs_oe[k] = {obs_oe[k][17:0], soe[k]};
          nbits[k]++;
        end
        if (prev_ct[k] && !ct[k]) fidx[k]++;
      end
      tdrv_en[k] = !rdy[k] && is_read[k] && respond[k] && fidx[k] >= 10 && fidx[k] <= 17;
      tdrv[k] = 1'b1;
      if (tdrv_en[k]) tdrv[k] = tdata[k][3'(17 - fidx[k])];
      if (rspv[k]) begin rsp_cnt[k]++; rsp_at[k] = since[k]; end
      prev_ct[k] = ct[k];
      prev_rdy[k] = rdy[k];
    end
  end
  // Expected {sdio_o, sdio_oe} per bit period, first bit most significant.
  function automatic logic [37:0] model_bits(input logic w, input logic [6:0] a, input logic [7:0] d);
    return w ? {1'b0, 1'b0, 1'b1, a, d, 1'b1, 1'b0, {17{1'b1}}, 1'b0}
             : {1'b0, 1'b0, a, 1'b1, 8'hFF, 1'b1, {9{1'b1}}, {10{1'b0}}};
  endfunction
  task automatic request(input int k, input logic w, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clock);
    while (!rdy[k] && n < 500) begin @(negedge clock); n++; end
    vectors++;
    if (!rdy[k]) begin miscompares++; $display("FAIL req_ready_wait k=%0d got=0 want=1", k); end
    rv[k] = 1'b1; rw[k] = w; ra[k] = a; wd[k] = d;
    @(posedge clock);
    #1 rv[k] = 1'b0; rw[k] = 1'($urandom); ra[k] = 7'($urandom); wd[k] = 8'($urandom);
  endtask
  task automatic wait_done(input int k);
    int n = 0;
    do begin @(negedge clock); n++; end while (!rdy[k] && n < 1000);
    vectors++;
    if (!rdy[k]) begin miscompares++; $display("FAIL frame_done_wait k=%0d got=0 want=1", k); end
    repeat (3) @(negedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({rdy[k], rspv[k], rdata[k], ct[k], so[k], soe[k]} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_outputs k=%0d got=%b want=%b", k, {rdy[k], rspv[k], rdata[k], ct[k], so[k], soe[k]}, 13'b1_0_00000000_1_1_0);
      end
    end
    reset_n = 1'b1;
    exp_rd = '0;
  endtask
  task automatic test_write();
    request(0, 1'b1, 7'h15, 8'hA5);
    wait_done(0);
    vectors++;
    if ({obs_o[0], obs_oe[0]} !== model_bits(1'b1, 7'h15, 8'hA5)) begin
      miscompares++; $display("FAIL write_bits got=%h want=%h", {obs_o[0], obs_oe[0]}, model_bits(1'b1, 7'h15, 8'hA5));
    end
    vectors++;
    if (busy[0] !== 72) begin miscompares++; $display("FAIL write_ready_low got=%0d want=72", busy[0]); end
    vectors++;
    if (low[0] !== 36) begin miscompares++; $display("FAIL write_clk_low got=%0d want=36", low[0]); end
    vectors++;
    if (rsp_cnt[0] !== 0) begin miscompares++; $display("FAIL write_rsp got=%0d want=0", rsp_cnt[0]); end
  endtask
  task automatic test_read();
    respond[0] = 1'b1; tdata[0] = 8'h81;
    request(0, 1'b0, 7'h00, 8'h5A);
    wait_done(0);
    exp_rd[0] = 8'h81;
    vectors++;
    if ({obs_o[0], obs_oe[0]} !== model_bits(1'b0, 7'h00, 8'h5A)) begin
      miscompares++; $display("FAIL read_bits got=%h want=%h", {obs_o[0], obs_oe[0]}, model_bits(1'b0, 7'h00, 8'h5A));
    end
    vectors++;
    if (busy[0] !== 76) begin miscompares++; $display("FAIL read_ready_low got=%0d want=76", busy[0]); end
    vectors++;
    if (rsp_cnt[0] !== 1 || rsp_at[0] !== 76) begin
      miscompares++; $display("FAIL read_rsp_pulse got=%0d@%0d want=1@76", rsp_cnt[0], rsp_at[0]);
    end
    vectors++;
    if (rdata[0] !== 8'h81) begin miscompares++; $display("FAIL read_rdata got=%h want=81", rdata[0]); end
  endtask
  task automatic test_back_to_back();
    logic [6:0] a1, a2;
    logic [7:0] d1, t;
    logic pr;
    int n_acc, idle;
    a1 = 7'($urandom); a2 = 7'($urandom); d1 = 8'($urandom); t = 8'($urandom);
    respond[0] = 1'b1; tdata[0] = t;
    @(negedge clock);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = a1; wd[0] = d1;
    @(posedge clock);
    #1 rw[0] = 1'b0; ra[0] = a2; wd[0] = 8'($urandom);
    n_acc = 1; idle = 0; pr = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (rdy[0] && n_acc < 2) idle++;
      if (pr && !rdy[0]) begin n_acc++; rv[0] = 1'b0; end
      pr = rdy[0];
    end
    #1;
    exp_rd[0] = t;
    vectors++;
    if (n_acc !== 2 || idle !== 1) begin
      miscompares++; $display("FAIL b2b_frames got=%0d frames gap=%0d want=2 frames gap=1", n_acc, idle);
    end
    vectors++;
    if ({obs_o[0], obs_oe[0]} !== model_bits(1'b0, a2, 8'h00)) begin
      miscompares++; $display("FAIL b2b_read_bits got=%h want=%h", {obs_o[0], obs_oe[0]}, model_bits(1'b0, a2, 8'h00));
    end
    vectors++;
    if (rsp_cnt[0] !== 1 || rdata[0] !== t) begin
      miscompares++; $display("FAIL b2b_read_rsp got=%0d/%h want=1/%h", rsp_cnt[0], rdata[0], t);
    end
  endtask
  task automatic test_random();
    logic w, resp;
    logic [6:0] a;
    logic [7:0] d, t;
    for (int i = 0; i < 10; i++) begin
      w = 1'($urandom); a = 7'($urandom); d = 8'($urandom); t = 8'($urandom);
      resp = ($urandom % 4) != 0;
      respond[0] = resp; tdata[0] = t;
      request(0, w, a, d);
      wait_done(0);
      if (!w) exp_rd[0] = resp ? t : 8'hFF;
      vectors++;
      if ({obs_o[0], obs_oe[0]} !== model_bits(w, a, d)) begin
        miscompares++; $display("FAIL rand_bits i=%0d got=%h want=%h", i, {obs_o[0], obs_oe[0]}, model_bits(w, a, d));
      end
      vectors++;
      if (busy[0] !== (w ? 72 : 76) || rsp_cnt[0] !== (w ? 0 : 1)) begin
        miscompares++; $display("FAIL rand_timing i=%0d got=%0d/%0d want=%0d/%0d", i, busy[0], rsp_cnt[0], w ? 72 : 76, w ? 0 : 1);
      end
      vectors++;
      if (rdata[0] !== exp_rd[0]) begin
        miscompares++; $display("FAIL rand_rdata i=%0d got=%h want=%h", i, rdata[0], exp_rd[0]);
      end
    end
  endtask
  task automatic test_reset_midframe();
    int n = 0;
    respond[0] = 1'b1; tdata[0] = 8'($urandom);
    request(0, 1'b0, 7'($urandom), 8'h00);
    do begin @(negedge clock); #1; n++; end while (fidx[0] != 6 && n < 300);
    vectors++;
    if (fidx[0] != 6) begin miscompares++; $display("FAIL abort_reach_cmd5 got=%0d want=6", fidx[0]); end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({ct[0], soe[0], so[0], rdy[0], rspv[0]} !== 5'b10110) begin
      miscompares++; $display("FAIL abort_immediate got=%b want=10110", {ct[0], soe[0], so[0], rdy[0], rspv[0]});
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_rd = '0;
    repeat (5) @(negedge clock);
    #1;
    vectors++;
    if (rsp_cnt[0] !== 0 || rdata[0] !== 8'h00) begin
      miscompares++; $display("FAIL abort_no_rsp got=%0d/%h want=0/00", rsp_cnt[0], rdata[0]);
    end
    tdata[0] = 8'h3C;
    request(0, 1'b0, 7'h2B, 8'h00);
    wait_done(0);
    exp_rd[0] = 8'h3C;
    vectors++;
    if ({obs_o[0], obs_oe[0]} !== model_bits(1'b0, 7'h2B, 8'h00) || rsp_cnt[0] !== 1 || rdata[0] !== 8'h3C) begin
      miscompares++; $display("FAIL abort_next_read got=%h/%0d/%h want=%h/1/3c", {obs_o[0], obs_oe[0]}, rsp_cnt[0], rdata[0], model_bits(1'b0, 7'h2B, 8'h00));
    end
  endtask
  task automatic test_clkdiv1();
    logic [6:0] a;
    logic [7:0] t;
    respond[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 7'($urandom);
      t = (i % 2 == 0) ? 8'hFF : 8'h00;
      tdata[1] = t;
      request(1, 1'b0, a, 8'h00);
      wait_done(1);
      vectors++;
      if ({obs_o[1], obs_oe[1]} !== model_bits(1'b0, a, 8'h00)) begin
        miscompares++; $display("FAIL div1_bits i=%0d got=%h want=%h", i, {obs_o[1], obs_oe[1]}, model_bits(1'b0, a, 8'h00));
      end
      vectors++;
      if (busy[1] !== 38 || low[1] !== 19 || rsp_at[1] !== 38 || rdata[1] !== t) begin
        miscompares++; $display("FAIL div1_read i=%0d got=%0d/%0d/%0d/%h want=38/19/38/%h", i, busy[1], low[1], rsp_at[1], rdata[1], t);
      end
    end
    request(1, 1'b1, 7'h7F, 8'h3C);
    wait_done(1);
    vectors++;
    if ({obs_o[1], obs_oe[1]} !== model_bits(1'b1, 7'h7F, 8'h3C) || busy[1] !== 36 || rsp_cnt[1] !== 0) begin
      miscompares++; $display("FAIL div1_write got=%h/%0d/%0d want=%h/36/0", {obs_o[1], obs_oe[1]}, busy[1], rsp_cnt[1], model_bits(1'b1, 7'h7F, 8'h3C));
    end
  endtask
  task automatic test_no_target();
    respond[0] = 1'b0; tdata[0] = 8'h00;
    request(0, 1'b0, 7'h11, 8'h00);
    wait_done(0);
    vectors++;
    if (rsp_cnt[0] !== 1 || rdata[0] !== 8'hFF) begin
      miscompares++; $display("FAIL no_target_rdata got=%0d/%h want=1/ff", rsp_cnt[0], rdata[0]);
    end
  endtask
  initial begin
    reset_n = 1'b0;
    rv = '0; rw = '0; ra = '0; wd = '0;
    respond = 2'b11; tdata = '0; exp_rd = '0;
    prev_ct = 2'b11; prev_rdy = 2'b11; is_read = '0; tdrv_en = '0; tdrv = 2'b11;
    obs_o = '0; obs_oe = '0;
    for (int k = 0; k < 2; k++) begin
      nbits[k] = 0; busy[k] = 0; low[k] = 0; rsp_cnt[k] = 0; rsp_at[k] = -1; since[k] = 0; fidx[k] = -1;
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_clkdiv1();
    test_no_target();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule

// File: doc/rio_initiator.md
RIO_INITIATOR -- requirements
Module: rio_initiator

Interface
REQ-001 SHALL have parameter CLKDIV, default 2: clock cycles per half period of clock_target; legal values are 1 to 255.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: transaction request.
REQ-005 SHALL have port req_ready, output, 1 bit: the engine is idle and accepts a request.
REQ-006 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, 7 bits: target register address.
REQ-008 SHALL have port req_wdata, input, 8 bits: write data.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle pulse when a read completes.
REQ-010 SHALL have port rsp_rdata, output, 8 bits: read data, valid while rsp_valid is high and held until the next read completes.
REQ-011 SHALL have port clock_target, output, 1 bit: serial clock to the target.
REQ-012 SHALL have ports sdio_o (output, 1 bit), sdio_oe (output, 1 bit) and sdio_i (input, 1 bit): the split tristate for the shared sdio line, which is externally pulled up.

Function
REQ-013 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; req_write, req_addr and req_wdata SHALL be captured in that cycle, and req_ready SHALL go low the following cycle.
REQ-014 One bit period SHALL be 2*CLKDIV clock cycles: clock_target is low for the first CLKDIV cycles and high for the last CLKDIV cycles; outside a frame, clock_target SHALL idle at 1.
REQ-015 The host SHALL change sdio_o only at the start of a bit period (falling edge of clock_target); the target samples on the rising edge.
REQ-016 Write frame: START (sdio 0), CMD (8 bits, MSB first: rw=1 then addr[6:0]), WDATA (8 bits, MSB first), END (1 bit with sdio_oe=0); total 18 bit periods.
REQ-017 Read frame: START, CMD (rw=0), TA (1 bit with sdio_oe=0), RDATA (8 bits, MSB first, target-driven), END (sdio_oe=0); total 19 bit periods.
REQ-018 In RDATA, sdio_i SHALL be sampled on the final clock cycle of each bit period and shifted in MSB first.
REQ-019 The state machine SHALL have states IDLE, START, CMD, WDATA, TA, RDATA, END; transitions are IDLE->START on accept, START->CMD, CMD->WDATA on write or CMD->TA on read, WDATA->END, TA->RDATA, RDATA->END, and END->IDLE.
REQ-020 Each state SHALL last exactly one bit period, except CMD, WDATA and RDATA, which last 8 bit periods, counted by a 3-bit bit counter that wraps 7->0 on the state exit.
REQ-021 rsp_valid SHALL pulse for exactly one cycle, on the cycle END->IDLE occurs, for read frames only; rsp_rdata SHALL update on that same cycle.
REQ-022 req_ready SHALL be 1 only in IDLE; it re-asserts on the cycle after END->IDLE, so the minimum request-to-request spacing is frame length plus 1 cycle.
REQ-023 sdio_oe SHALL be 1 only in START, CMD and WDATA; whenever sdio_oe is 0, sdio_o SHALL be 1.
REQ-024 Request inputs SHALL be ignored while req_ready is 0.

Reset
REQ-025 While reset_n is 0: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=8'h00, clock_target=1, sdio_o=1, sdio_oe=0, counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously, with no rsp_valid; after reset_n rises, the next frame SHALL start cleanly from START.

Structure
REQ-027 Package rio_pkg SHALL hold the state enum, the CMD/DATA bit count (8), and the write and read frame lengths (18/19).
REQ-028 Sub-module rio_bit_timer SHALL generate the half-period tick, the end-of-bit strobe and clock_target from CLKDIV; all other logic stays in rio_initiator.

Verification
REQ-029 Scenario: CLKDIV=2, write addr 7'h15, data 8'hA5 -> sdio bits 0,1,0010101,10100101; req_ready low for 72 cycles; no rsp_valid.
REQ-030 Scenario: read addr 7'h00 with a target model returning 8'h81 -> rsp_valid single pulse, rsp_rdata=8'h81, 76 cycles after accept; sdio_oe=0 from TA onward.
REQ-031 Scenario: req_valid held high over back-to-back write then read -> exactly two frames, second START begins 1 cycle after req_ready returns.
REQ-032 Scenario: reset_n pulsed low at bit 5 of CMD -> clock_target=1 and sdio_oe=0 immediately; no rsp_valid; the following read of 8'h3C completes correctly.
REQ-033 Scenario: CLKDIV=1, read with the target driving 8'hFF and 8'h00 alternately -> correct sampling at 2-cycle bit periods; a 19-bit frame takes 38 cycles.
REQ-034 Scenario: read with no target response (line pulled up) -> rsp_rdata=8'hFF.
